// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Purpose  : Scans a 4x4 matrix keypad by strobing the rows one-hot and
//             reading the column lines back. Each press is debounced and
//             reported once as a 4-bit key code (row_index*4 + col_index).
//  Ports    : clk       - system clock, rising edge
//             rst       - asynchronous, active-high reset
//             col[3:0]  - keypad column lines, active-high, async to clk
//             row[3:0]  - one-hot active-high row strobe
//             key[3:0]  - last accepted key code
//             key_valid - one-clock pulse per accepted press
//             key_held  - high while the accepted key is still pressed
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,  // clocks per row dwell (>= 2)
  parameter int DEBOUNCE = 4      // matching / empty samples to accept (>= 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  // --------------------------------------------------------------------------
  // Widths and constants
  // --------------------------------------------------------------------------
  localparam int DW = (SCAN_DIV < 3) ? 1 : $clog2(SCAN_DIV);
  localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [CW-1:0] DB_TARGET = CW'(DEBOUNCE);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [3:0]    col_meta;
  logic [3:0]    col_s;
  logic [DW-1:0] div_cnt;
  logic [1:0]    state;
  logic [3:0]    cand;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] rel_cnt;

  // Next-state values
  logic [1:0]    state_n;
  logic [3:0]    row_n;
  logic [3:0]    cand_n;
  logic [CW-1:0] db_cnt_n;
  logic [CW-1:0] rel_cnt_n;
  logic [3:0]    key_n;
  logic          key_valid_n;
  logic          key_held_n;

  // Decode helpers
  logic          tick;
  logic          col_any;
  logic [1:0]    col_index;
  logic [1:0]    row_index;
  logic [3:0]    code;
  logic [3:0]    row_rot;
  logic [CW-1:0] db_inc;
  logic [CW-1:0] rel_inc;

  assign tick    = (div_cnt == DIV_LAST);
  assign col_any = |col_s;
  assign row_rot = {row[2:0], row[3]};
  assign db_inc  = db_cnt + CNT_ONE;
  assign rel_inc = rel_cnt + CNT_ONE;
  assign code    = {row_index, col_index};

  // Several columns at once resolve to the lowest-numbered one
  always_comb begin
    col_index = 2'd3;
    if (col_s[0])      col_index = 2'd0;
    else if (col_s[1]) col_index = 2'd1;
    else if (col_s[2]) col_index = 2'd2;
  end

  always_comb begin
    case (row)
      4'b0010: row_index = 2'd1;
      4'b0100: row_index = 2'd2;
      4'b1000: row_index = 2'd3;
      default: row_index = 2'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Scan / debounce / hold state machine. Everything advances on ticks only;
  // the row is frozen whenever the machine is away from SCAN so that keys on
  // other rows cannot disturb a press in progress.
  // --------------------------------------------------------------------------
  always_comb begin
    state_n     = state;
    row_n       = row;
    cand_n      = cand;
    db_cnt_n    = db_cnt;
    rel_cnt_n   = rel_cnt;
    key_n       = key;
    key_valid_n = 1'b0;
    key_held_n  = key_held;

    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (!col_any) begin
            row_n = row_rot;
          end else begin
            cand_n   = code;
            db_cnt_n = CNT_ONE;
            if (DB_TARGET == CNT_ONE) begin
              // Single-sample debounce: accept on the detecting tick
              state_n     = ST_HOLD;
              key_n       = code;
              key_valid_n = 1'b1;
              key_held_n  = 1'b1;
              rel_cnt_n   = '0;
            end else begin
              state_n = ST_DEBOUNCE;
            end
          end
        end

        ST_DEBOUNCE: begin
          if (col_any && (code == cand)) begin
            db_cnt_n = db_inc;
            if (db_inc == DB_TARGET) begin
              state_n     = ST_HOLD;
              key_n       = cand;
              key_valid_n = 1'b1;
              key_held_n  = 1'b1;
              rel_cnt_n   = '0;
            end
          end else begin
            // Bounce or different key: abandon and keep scanning
            state_n  = ST_SCAN;
            row_n    = row_rot;
            db_cnt_n = '0;
          end
        end

        ST_HOLD: begin
          if (!col_any) begin
            rel_cnt_n = rel_inc;
            if (rel_inc == DB_TARGET) begin
              state_n    = ST_SCAN;
              row_n      = row_rot;
              key_held_n = 1'b0;
              rel_cnt_n  = '0;
              db_cnt_n   = '0;
            end
          end else begin
            // Any contact restarts the release count
            rel_cnt_n = '0;
          end
        end

        default: begin
          state_n  = ST_SCAN;
          row_n    = 4'b0001;
          db_cnt_n = '0;
          rel_cnt_n = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta  <= 4'b0000;
      col_s     <= 4'b0000;
      div_cnt   <= '0;
      state     <= ST_SCAN;
      row       <= 4'b0001;
      cand      <= 4'b0000;
      db_cnt    <= '0;
      rel_cnt   <= '0;
      key       <= 4'b0000;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      // Two-flop synchronizer: col is asynchronous to clk
      col_meta  <= col;
      col_s     <= col_meta;
      div_cnt   <= tick ? '0 : (div_cnt + DIV_ONE);
      state     <= state_n;
      row       <= row_n;
      cand      <= cand_n;
      db_cnt    <= db_cnt_n;
      rel_cnt   <= rel_cnt_n;
      key       <= key_n;
      key_valid <= key_valid_n;
      key_held  <= key_held_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scanner
//  Purpose  : Directed self-checking bench for keypad_scanner with
//             SCAN_DIV=4, DEBOUNCE=3. A small keypad model closes the
//             selected row onto the selected columns.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  // Keypad model: pressed switches connect press_row to press_col
  logic [3:0] press_row;
  logic [3:0] press_col;

  int tests;
  int fails;
  int vcount;

  keypad_scanner #(
    .SCAN_DIV (4),
    .DEBOUNCE (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb col = ((row & press_row) != 4'b0000) ? press_col : 4'b0000;

  // Count key_valid pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (key_valid === 1'b1) vcount++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests     = 0;
    fails     = 0;
    vcount    = 0;
    rst       = 1'b1;
    press_row = 4'b0000;
    press_col = 4'b0000;

    // ---------------- reset and idle scan ----------------
    step(2);
    check("rst_row",   row,       4'b0001);
    check("rst_key",   key,       4'd0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held",  key_held,  1'b0);
    rst = 1'b0;
    step(3);
    check("idle_row0", row, 4'b0001);
    step(1);
    check("idle_row1", row, 4'b0010);
    step(4);
    check("idle_row2", row, 4'b0100);
    step(4);
    check("idle_row3", row, 4'b1000);
    step(4);
    check("idle_wrap", row, 4'b0001);
    check("idle_vcnt", vcount, 0);
    check("idle_key",  key, 4'd0);
    check("idle_held", key_held, 1'b0);

    // ---------------- key 6: row 0010, col 0100 ----------------
    press_row = 4'b0010;
    press_col = 4'b0100;
    step(4);
    check("k6_row", row, 4'b0010);
    step(4);                       // detection tick, count 1
    check("k6_det_valid", key_valid, 1'b0);
    check("k6_det_row",   row, 4'b0010);
    step(4);                       // count 2
    check("k6_c2_valid", key_valid, 1'b0);
    step(4);                       // count 3: accept
    check("k6_valid", key_valid, 1'b1);
    check("k6_key",   key, 4'd6);
    check("k6_held",  key_held, 1'b1);
    step(1);
    check("k6_pulse_end", key_valid, 1'b0);
    step(99);
    check("k6_hold_held", key_held, 1'b1);
    check("k6_hold_row",  row, 4'b0010);
    check("k6_hold_vcnt", vcount, 1);
    press_col = 4'b0000;
    step(8);
    check("k6_rel2_held", key_held, 1'b1);
    step(4);
    check("k6_rel_held", key_held, 1'b0);
    check("k6_rel_row",  row, 4'b0100);
    check("k6_rel_key",  key, 4'd6);
    check("k6_rel_vcnt", vcount, 1);

    // ---------------- bounce during debounce ----------------
    step(12);
    check("bnc_row", row, 4'b0010);
    for (int i = 0; i < 2; i++) begin
      press_col = 4'b0100;
      step(4);
      press_col = 4'b0000;
      step(4);
      check("bnc_abort_row", row, 4'b0100);
      check("bnc_vcnt", vcount, 1);
      check("bnc_key", key, 4'd6);
      step(12);
    end

    // ---------------- bounce during hold ----------------
    press_col = 4'b0100;
    step(12);
    check("hb_held", key_held, 1'b1);
    press_col = 4'b0000;
    step(8);
    check("hb_vcnt", vcount, 2);
    press_col = 4'b0100;
    step(4);                       // contact restarts release count
    press_col = 4'b0000;
    step(8);
    check("hb_still_held", key_held, 1'b1);
    check("hb_row", row, 4'b0010);
    step(4);
    check("hb_rel_held", key_held, 1'b0);
    check("hb_rel_row",  row, 4'b0100);

    // ---------------- multi-column: row 1000, col 1010 -> 13 ----------------
    press_row = 4'b1000;
    press_col = 4'b1010;
    step(4);
    check("k13_row", row, 4'b1000);
    step(12);
    check("k13_valid", key_valid, 1'b1);
    check("k13_key",   key, 4'd13);
    press_col = 4'b0000;
    step(12);
    check("k13_rel_held", key_held, 1'b0);
    check("k13_rel_row",  row, 4'b0001);
    check("k13_rel_key",  key, 4'd13);
    check("k13_vcnt",     vcount, 3);

    // ---------------- reset mid-debounce ----------------
    press_row = 4'b0001;
    press_col = 4'b0010;
    step(8);                       // two matching ticks
    check("rd_valid", key_valid, 1'b0);
    rst = 1'b1;
    #1;
    check("rd_row",   row, 4'b0001);
    check("rd_key",   key, 4'd0);
    check("rd_valid0", key_valid, 1'b0);
    check("rd_held",  key_held, 1'b0);
    rst = 1'b0;
    step(8);                       // count restarts: only 2 ticks so far
    check("rd_re_valid", key_valid, 1'b0);
    check("rd_re_held",  key_held, 1'b0);
    step(4);
    check("rd_acc_valid", key_valid, 1'b1);
    check("rd_acc_key",   key, 4'd1);
    step(1);
    check("rd_acc_held", key_held, 1'b1);

    // ---------------- reset mid-hold ----------------
    rst = 1'b1;
    #1;
    check("rh_row",  row, 4'b0001);
    check("rh_key",  key, 4'd0);
    check("rh_held", key_held, 1'b0);
    rst = 1'b0;
    step(4);                       // detection only
    check("rh_re_key",  key, 4'd0);
    check("rh_re_held", key_held, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
